// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC-source encodings, the NOP word,
// the fetch FSM state type and the prefetch queue entry layout.
package cpu_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_J   = 2'b10;
    localparam logic [1:0] PCS_JR  = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_WAIT = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } fetch_entry_t;

    // Only branches use bpc; both jump encodings take jpc.
    function automatic logic [31:0] redirect_target(input logic [1:0]  pcs,
                                                     input logic [31:0] bpc,
                                                     input logic [31:0] jpc);
        return (pcs == PCS_BR) ? bpc : jpc;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc+4, instruction}, head visible
// combinationally, with a flush that empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs one outstanding
// req/ack read at a time and buffers returned words for the IF/ID register.
module if_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic        if_valid,
    output logic [31:0] if_Inst,
    output logic [31:0] if_pc4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc;
    logic [31:0]      req_addr;
    logic [31:0]      target;
    logic             redirect;
    logic             issue;
    logic             accept;
    logic             push;
    logic             pop;
    fetch_entry_t     entry;
    fetch_entry_t     head;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    assign redirect = (pcsource != PCS_SEQ);
    assign target   = redirect_target(pcsource, bpc, jpc);
    // A redirect cycle never issues: the new target goes out next cycle.
    assign issue    = (state == FETCH_IDLE) && !redirect && (count < CNT_W'(DEPTH));
    assign accept   = (state == FETCH_WAIT) && imem_ack && !redirect;
    assign push     = accept && (!full || pop);
    assign pop      = if_valid && !id_stall;
    assign entry    = '{pc4: req_addr + 32'd4, inst: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (Clock),
        .rst   (Resetn),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) state <= FETCH_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH_IDLE: if (issue) state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem_ack)      state_next = FETCH_IDLE;
                else if (redirect) state_next = FETCH_DROP;
            end
            FETCH_DROP: if (imem_ack) state_next = FETCH_IDLE;
            default:    state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = !Resetn && (issue || (state != FETCH_IDLE));
        imem_addr = (state == FETCH_IDLE) ? pc : req_addr;
        if_valid  = !empty && !redirect;
        if_Inst   = if_valid ? head.inst : NOP_INST;
        if_pc4    = if_valid ? head.pc4  : 32'h0;
    end

    // req_addr holds the address on the bus while pc may already point
    // at a redirect target (DROP).
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect)    pc <= target;
            else if (accept) pc <= pc + 32'd4;
            if (issue) req_addr <= pc;
        end
    end

    assign PC = pc;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: variable-latency memory responder, a
// scoreboard of expected instructions, and one task per scenario.
module tb_if_prefetch_unit;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic        id_stall = 1'b0;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] PC;
    logic        if_valid;
    logic [31:0] if_Inst;
    logic [31:0] if_pc4;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_PC;
    logic        w_valid;
    logic [31:0] w_Inst;
    logic [31:0] w_pc4;

    int   total = 0;
    int   bad = 0;
    int   lat = 1;
    exp_t q[$];
    logic dropping = 1'b0;
    logic [31:0] exp_pc = 32'h0;

    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .Clock(Clock), .Resetn(Resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC),
        .if_valid(if_valid), .if_Inst(if_Inst), .if_pc4(if_pc4)
    );

    // Shares every input with dut, so its handshake timing is identical.
    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clock(Clock), .Resetn(Resetn), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .id_stall(id_stall), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(w_PC),
        .if_valid(w_valid), .if_Inst(w_Inst), .if_pc4(w_pc4)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
    endfunction

    // Memory: ack arrives lat cycles after the request first appears.
    initial begin : responder
        int  cnt;
        logic nxt;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge Clock);
            if (Resetn || imem_ack || !imem_req) begin
                cnt = 0;
                nxt = 1'b0;
            end else begin
                cnt++;
                nxt = (cnt >= lat);
            end
            @(posedge Clock);
            #1;
            imem_ack = nxt;
            imem_rdata = nxt ? mem_word(imem_addr) : 32'h0;
        end
    end

    // Scoreboard: expected entries pushed on accepted acks, popped on consumption.
    initial begin : monitor
        logic        redir;
        logic        exp_valid;
        logic [31:0] tgt;
        exp_t        e;
        forever begin
            @(negedge Clock);
            if (Resetn) begin
                q.delete();
                dropping = 1'b0;
                exp_pc = 32'h0;
            end else begin
                redir = (pcsource != 2'b00);
                tgt = (pcsource == 2'b01) ? bpc : jpc;
                exp_valid = (q.size() > 0) && !redir;
                total++;
                if (if_valid !== exp_valid) begin
                    bad++;
                    $display("FAIL sb_valid: got %b want %b at %0t", if_valid, exp_valid, $time);
                end else if (exp_valid) begin
                    e = q[0];
                    total++;
                    if ({if_pc4, if_Inst} !== {e.pc4, e.inst}) begin
                        bad++;
                        $display("FAIL sb_data: got pc4=%h inst=%h want pc4=%h inst=%h",
                                 if_pc4, if_Inst, e.pc4, e.inst);
                    end
                end else begin
                    total++;
                    if ({if_pc4, if_Inst} !== 64'h0) begin
                        bad++;
                        $display("FAIL sb_nop: got pc4=%h inst=%h want 0", if_pc4, if_Inst);
                    end
                end
                if (exp_valid && !id_stall) void'(q.pop_front());
                if (redir) q.delete();
                if (imem_ack) begin
                    if (!redir && !dropping) begin
                        total++;
                        if (imem_addr !== exp_pc) begin
                            bad++;
                            $display("FAIL sb_addr: got %h want %h", imem_addr, exp_pc);
                        end
                        q.push_back('{pc4: exp_pc + 32'd4, inst: mem_word(exp_pc)});
                        exp_pc = exp_pc + 32'd4;
                    end
                    dropping = 1'b0;
                end else if (redir && imem_req) begin
                    dropping = 1'b1;
                end
                if (redir) exp_pc = tgt;
                total++;
                if (q.size() > DEPTH) begin
                    bad++;
                    $display("FAIL overflow: queue holds %0d want <= %0d", q.size(), DEPTH);
                end
            end
        end
    end

    task automatic do_reset(input logic stall, input int latency);
        lat = latency;
        id_stall = stall;
        pcsource = 2'b00;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        repeat (2) @(negedge Clock);
        @(posedge Clock); #1;
        Resetn = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (imem_req !== 1'b0) begin
                bad++; $display("FAIL reset_req: got %b want 0", imem_req);
            end
        end
        total++;
        if ({PC, imem_addr} !== 64'h0) begin
            bad++; $display("FAIL reset_pc: got PC=%h addr=%h want 0", PC, imem_addr);
        end
        total++;
        if ({if_valid, if_Inst, if_pc4} !== 65'h0) begin
            bad++; $display("FAIL reset_out: got v=%b inst=%h pc4=%h want 0", if_valid, if_Inst, if_pc4);
        end
        @(posedge Clock); #1;
        Resetn = 1'b0;
        @(negedge Clock);
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] addrs [3];
        logic [31:0] pcs [3];
        int na = 0;
        int nv = 0;
        for (int i = 0; i < 3; i++) begin
            addrs[i] = 32'hDEAD_BEEF;
            pcs[i] = 32'hDEAD_BEEF;
        end
        do_reset(1'b0, 1);
        for (int c = 0; c < 30 && (na < 3 || nv < 3); c++) begin
            @(negedge Clock);
            if (imem_ack && na < 3) begin addrs[na] = imem_addr; na++; end
            if (if_valid && nv < 3) begin pcs[nv] = if_pc4; nv++; end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (addrs[i] !== 32'(4 * i)) begin
                bad++; $display("FAIL stream_addr%0d: got %h want %h", i, addrs[i], 32'(4 * i));
            end
            total++;
            if (pcs[i] !== 32'(4 * i + 4)) begin
                bad++; $display("FAIL stream_pc4_%0d: got %h want %h", i, pcs[i], 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1'b1, 1);
        repeat (5) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge Clock);
            total++;
            if ({imem_req, if_valid, if_pc4} !== {1'b0, 1'b1, 32'h4}) begin
                bad++; $display("FAIL stall_full: got req=%b v=%b pc4=%h want 0/1/4", imem_req, if_valid, if_pc4);
            end
        end
        @(posedge Clock); #1;
        id_stall = 1'b0;
        @(negedge Clock);
        total++;
        if ({imem_req, if_pc4} !== {1'b0, 32'h4}) begin
            bad++; $display("FAIL stall_pop1: got req=%b pc4=%h want 0/4", imem_req, if_pc4);
        end
        @(negedge Clock);
        total++;
        if ({imem_req, imem_addr, if_pc4} !== {1'b1, 32'h8, 32'h8}) begin
            bad++; $display("FAIL stall_resume: got req=%b addr=%h pc4=%h want 1/8/8", imem_req, imem_addr, if_pc4);
        end
    endtask

    task automatic test_branch_drop();
        logic found = 1'b0;
        do_reset(1'b0, 4);
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge Clock);
            if (imem_req && !imem_ack && imem_addr == 32'h8) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL br_timeout: got no request to 8 want one"); end
        @(posedge Clock); #1;
        pcsource = 2'b01; bpc = 32'h40;
        @(negedge Clock);
        total++;
        if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h8}) begin
            bad++; $display("FAIL br_cycle: got v=%b req=%b addr=%h want 0/1/8", if_valid, imem_req, imem_addr);
        end
        @(posedge Clock); #1;
        pcsource = 2'b00;
        @(negedge Clock);
        total++;
        if ({imem_req, imem_addr, PC} !== {1'b1, 32'h8, 32'h40}) begin
            bad++; $display("FAIL br_drop_hold: got req=%b addr=%h PC=%h want 1/8/40", imem_req, imem_addr, PC);
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock);
            if (imem_ack) found = 1'b1;
        end
        total++;
        if (!found || imem_addr !== 32'h8) begin
            bad++; $display("FAIL br_drop_ack: got ack=%b addr=%h want 1/8", found, imem_addr);
        end
        @(negedge Clock);
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
            bad++; $display("FAIL br_target: got req=%b addr=%h want 1/40", imem_req, imem_addr);
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock);
            if (if_valid) found = 1'b1;
        end
        total++;
        if (!found || if_pc4 !== 32'h44) begin
            bad++; $display("FAIL br_first: got v=%b pc4=%h want 1/44", found, if_pc4);
        end
    endtask

    task automatic test_jump_ack();
        logic found = 1'b0;
        do_reset(1'b1, 1);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock);
            if (imem_req && !imem_ack && imem_addr == 32'h4) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL j_timeout: got no request to 4 want one"); end
        @(posedge Clock); #1;
        pcsource = 2'b10; jpc = 32'h100;
        @(negedge Clock);
        total++;
        if ({imem_ack, if_valid, if_Inst} !== {1'b1, 1'b0, 32'h0}) begin
            bad++; $display("FAIL j_same_cycle: got ack=%b v=%b inst=%h want 1/0/0", imem_ack, if_valid, if_Inst);
        end
        @(posedge Clock); #1;
        pcsource = 2'b00;
        @(negedge Clock);
        total++;
        if ({if_valid, imem_req, imem_addr, PC} !== {1'b0, 1'b1, 32'h100, 32'h100}) begin
            bad++; $display("FAIL j_flush: got v=%b req=%b addr=%h PC=%h want 0/1/100/100",
                            if_valid, imem_req, imem_addr, PC);
        end
        @(posedge Clock); #1;
        id_stall = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock);
            if (if_valid) found = 1'b1;
        end
        total++;
        if (!found || if_pc4 !== 32'h104) begin
            bad++; $display("FAIL j_first: got v=%b pc4=%h want 1/104", found, if_pc4);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b0, 1);
        @(negedge Clock);
        total++;
        if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            bad++; $display("FAIL wrap_first: got req=%b addr=%h want 1/fffffffc", w_req, w_addr);
        end
        repeat (2) @(negedge Clock);
        total++;
        if ({w_req, w_addr, w_PC} !== {1'b1, 32'h0, 32'h0}) begin
            bad++; $display("FAIL wrap_second: got req=%b addr=%h PC=%h want 1/0/0", w_req, w_addr, w_PC);
        end
        total++;
        if ({w_valid, w_pc4, w_Inst} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            bad++; $display("FAIL wrap_pc4: got v=%b pc4=%h inst=%h want 1/0/%h",
                            w_valid, w_pc4, w_Inst, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_mid();
        logic found = 1'b0;
        do_reset(1'b0, 3);
        repeat (2) @(negedge Clock);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        @(negedge Clock);
        total++;
        if ({imem_req, if_valid, PC, imem_addr} !== {2'b00, 64'h0}) begin
            bad++; $display("FAIL rmid_clear: got req=%b v=%b PC=%h addr=%h want 0/0/0/0",
                            imem_req, if_valid, PC, imem_addr);
        end
        @(posedge Clock); #1;
        Resetn = 1'b0;
        @(negedge Clock);
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            bad++; $display("FAIL rmid_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge Clock);
            if (if_valid) found = 1'b1;
        end
        total++;
        if (!found || if_pc4 !== 32'h4) begin
            bad++; $display("FAIL rmid_first: got v=%b pc4=%h want 1/4", found, if_pc4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch_drop();
        test_jump_ack();
        test_wrap();
        test_reset_mid();
        repeat (3) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
